// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, opcode classes and memory-stage state type
package pipe_pkg;

    localparam int INSTR_W    = 20;
    localparam int DATA_W     = 20;
    localparam int REG_ADDR_W = 4;

    localparam logic [3:0] OP_LOAD  = 4'b1111;
    localparam logic [3:0] OP_LOADI = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1100;

    // Opcode 1100 with no register write: write-back treats it as a no-op
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 20'hC0000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_LOADI);
    endfunction

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port synchronous data RAM, read-during-write returns old data
module data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write when enabled; read the pre-write word, returning 0 beyond DEPTH
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (32'(addr_i) < DEPTH) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage with latency stall; optional MEMSTAGE_RANGE_CHECK_EN adds range_error
module memory_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [INSTR_W-1:0]    instruction_in,
    input  logic [DATA_W-1:0]     aluResult_in,
    input  logic [DATA_W-1:0]     storeData_in,
    input  logic [REG_ADDR_W-1:0] address_in,
    output logic                  stall,
    output logic [INSTR_W-1:0]    instruction,
    output logic [DATA_W-1:0]     aluRESULTout,
    output logic [DATA_W-1:0]     memoryReadData,
    output logic [REG_ADDR_W-1:0] address,
`ifdef MEMSTAGE_RANGE_CHECK_EN
    output logic                  range_error,
`endif
    output logic                  valid_out
);

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [INSTR_W-1:0]      cap_instr_q;
    logic [DATA_W-1:0]       cap_alu_q;
    logic [DATA_W-1:0]       cap_sdata_q;
    logic [REG_ADDR_W-1:0]   cap_addr_q;

    logic [INSTR_W-1:0]      instr_q;
    logic [DATA_W-1:0]       alu_q;
    logic [REG_ADDR_W-1:0]   addr_q;
    logic                    valid_q;
    logic                    load_q;

    logic [INSTR_W-1:0]      sel_instr;
    logic [DATA_W-1:0]       sel_alu;
    logic [DATA_W-1:0]       sel_sdata;
    logic [REG_ADDR_W-1:0]   sel_addr;
    logic                    sel_load, sel_store, sel_mem, in_range;
    logic                    issue, capture, ram_we;
    logic [DATA_W-1:0]       ram_rdata;

    // While BUSY the access runs on captured operands, not the held inputs
    always_comb begin
        sel_instr = (state_q == BUSY) ? cap_instr_q : instruction_in;
        sel_alu   = (state_q == BUSY) ? cap_alu_q   : aluResult_in;
        sel_sdata = (state_q == BUSY) ? cap_sdata_q : storeData_in;
        sel_addr  = (state_q == BUSY) ? cap_addr_q  : address_in;
        sel_load  = is_load_op(sel_instr[19:16]);
        sel_store = (sel_instr[19:16] == OP_STORE);
        sel_mem   = sel_load || sel_store;
        in_range  = (32'(sel_alu[ADDR_W-1:0]) < DEPTH);
    end

    // Next-state, stall and issue decision; reset kills stall and any pending store
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (sel_mem && (MEM_LATENCY > 1)) begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_W'(MEM_LATENCY - 2);
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    issue   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
        ram_we = issue && sel_store && in_range && !reset;
    end

    // State and latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture when a multi-cycle access is accepted
    always_ff @(posedge clock) begin
        if (capture) begin
            cap_instr_q <= instruction_in;
            cap_alu_q   <= aluResult_in;
            cap_sdata_q <= storeData_in;
            cap_addr_q  <= address_in;
        end
    end

    // MEM/WB boundary: issued instruction or a bubble
    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            instr_q <= BUBBLE_INSTR;
            alu_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            instr_q <= sel_instr;
            alu_q   <= sel_alu;
            addr_q  <= sel_addr;
            valid_q <= 1'b1;
            load_q  <= sel_load && in_range;
        end
    end

`ifdef MEMSTAGE_RANGE_CHECK_EN
    logic range_err_q;

    // One-cycle flag for an out-of-range memory access
    always_ff @(posedge clock) begin
        if (reset) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= issue && sel_mem && !in_range;
        end
    end

    assign range_error = range_err_q;
`endif

    data_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .addr_i  (sel_alu[ADDR_W-1:0]),
        .wdata_i (sel_sdata),
        .rdata_o (ram_rdata)
    );

    assign instruction    = instr_q;
    assign aluRESULTout   = alu_q;
    assign address        = addr_q;
    assign valid_out      = valid_q;
    assign memoryReadData = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed checks for memory_stage at latency 1 and latency 3
module tb_memory_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: MEM_LATENCY = 1, DEPTH = 256
    logic        va;
    logic [19:0] ia, aa, sa;
    logic [3:0]  da;
    logic        stall_a, vo_a;
    logic [19:0] instr_a, alu_a, mrd_a;
    logic [3:0]  addr_a;

    // Instance B: MEM_LATENCY = 3, DEPTH = 200
    logic        vb;
    logic [19:0] ib, ab, sb;
    logic [3:0]  db;
    logic        stall_b, vo_b;
    logic [19:0] instr_b, alu_b, mrd_b;
    logic [3:0]  addr_b;
`ifdef MEMSTAGE_RANGE_CHECK_EN
    logic        rerr_a, rerr_b;
`endif

    memory_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(1)) u_a (
        .clock(clk), .reset(rst), .valid_in(va), .instruction_in(ia),
        .aluResult_in(aa), .storeData_in(sa), .address_in(da),
        .stall(stall_a), .instruction(instr_a), .aluRESULTout(alu_a),
        .memoryReadData(mrd_a), .address(addr_a),
`ifdef MEMSTAGE_RANGE_CHECK_EN
        .range_error(rerr_a),
`endif
        .valid_out(vo_a)
    );

    memory_stage #(.DEPTH(200), .ADDR_W(8), .MEM_LATENCY(3)) u_b (
        .clock(clk), .reset(rst), .valid_in(vb), .instruction_in(ib),
        .aluResult_in(ab), .storeData_in(sb), .address_in(db),
        .stall(stall_b), .instruction(instr_b), .aluRESULTout(alu_b),
        .memoryReadData(mrd_b), .address(addr_b),
`ifdef MEMSTAGE_RANGE_CHECK_EN
        .range_error(rerr_b),
`endif
        .valid_out(vo_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [19:0] ins, alu, sd;
        logic [3:0]  ad;
        logic [19:0] e_ins, e_alu, e_mrd;
        logic [3:0]  e_ad;
        logic        e_v;
    } vec_t;

    vec_t vecs[9];

    // Multi-cycle access on B: stall for 2 cycles with bubbles, result on the 3rd edge
    task automatic mem_b(input logic [19:0] ins, input logic [19:0] alu,
                         input logic [19:0] sd, input logic [3:0] ad);
        vb = 1'b1; ib = ins; ab = alu; sb = sd; db = ad;
        #1 chk("b_stall_c0", 32'(stall_b), 32'd1);
        @(posedge clk); #1;
        chk("b_bubble1_valid", 32'(vo_b), 32'd0);
        chk("b_bubble1_instr", 32'(instr_b), 32'hC0000);
        chk("b_stall_c1", 32'(stall_b), 32'd1);
        @(posedge clk); #1;
        chk("b_bubble2_valid", 32'(vo_b), 32'd0);
        chk("b_stall_c2", 32'(stall_b), 32'd0);
        // Perturb held inputs: the captured operands must be used
        ab = alu ^ 20'h00003; sb = ~sd; db = ~ad;
        @(posedge clk); #1;
    endtask

    initial begin
        // index 5 store/load, wrap via 0x1FF -> 0xFF, overwrite of 5
        vecs[0] = '{1'b1, 20'h30005, 20'h0000A, 20'h0, 4'h7, 20'h30005, 20'h0000A, 20'h0, 4'h7, 1'b1};
        vecs[1] = '{1'b1, 20'hC0000, 20'h00005, 20'hABCDE, 4'h0, 20'hC0000, 20'h00005, 20'h0, 4'h0, 1'b1};
        vecs[2] = '{1'b1, 20'hF0000, 20'h00005, 20'h0, 4'h3, 20'hF0000, 20'h00005, 20'hABCDE, 4'h3, 1'b1};
        vecs[3] = '{1'b0, 20'hF1234, 20'h00005, 20'h0, 4'h9, 20'hC0000, 20'h0, 20'h0, 4'h0, 1'b0};
        vecs[4] = '{1'b1, 20'hC0000, 20'h001FF, 20'h12345, 4'h1, 20'hC0000, 20'h001FF, 20'h0, 4'h1, 1'b1};
        vecs[5] = '{1'b1, 20'hD0000, 20'h000FF, 20'h0, 4'h2, 20'hD0000, 20'h000FF, 20'h12345, 4'h2, 1'b1};
        vecs[6] = '{1'b1, 20'h01234, 20'h55555, 20'h77777, 4'hF, 20'h01234, 20'h55555, 20'h0, 4'hF, 1'b1};
        vecs[7] = '{1'b1, 20'hC0000, 20'h00005, 20'h11111, 4'h4, 20'hC0000, 20'h00005, 20'h0, 4'h4, 1'b1};
        vecs[8] = '{1'b1, 20'hF0000, 20'h00005, 20'h0, 4'h5, 20'hF0000, 20'h00005, 20'h11111, 4'h5, 1'b1};

        rst = 1'b1;
        va = 1'b0; ia = '0; aa = '0; sa = '0; da = '0;
        vb = 1'b0; ib = '0; ab = '0; sb = '0; db = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_instr", 32'(instr_a), 32'hC0000);
        chk("rst_a_valid", 32'(vo_a), 32'd0);
        chk("rst_a_stall", 32'(stall_a), 32'd0);
        chk("rst_b_instr", 32'(instr_b), 32'hC0000);
        chk("rst_b_valid", 32'(vo_b), 32'd0);
        chk("rst_b_stall", 32'(stall_b), 32'd0);
        rst = 1'b0;

        // Latency-1 instance: one instruction per cycle from the table
        for (int i = 0; i < 9; i++) begin
            va = vecs[i].v; ia = vecs[i].ins; aa = vecs[i].alu; sa = vecs[i].sd; da = vecs[i].ad;
            #1 chk($sformatf("a%0d_stall", i), 32'(stall_a), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("a%0d_instr", i), 32'(instr_a), 32'(vecs[i].e_ins));
            chk($sformatf("a%0d_alu", i), 32'(alu_a), 32'(vecs[i].e_alu));
            chk($sformatf("a%0d_mrd", i), 32'(mrd_a), 32'(vecs[i].e_mrd));
            chk($sformatf("a%0d_addr", i), 32'(addr_a), 32'(vecs[i].e_ad));
            chk($sformatf("a%0d_valid", i), 32'(vo_a), 32'(vecs[i].e_v));
        end
        va = 1'b0;

        // Latency-3: store then load idx 9, followed by an ALU op
        mem_b(20'hC0000, 20'h00009, 20'h0BEEF, 4'h0);
        chk("b_st9_valid", 32'(vo_b), 32'd1);
        chk("b_st9_instr", 32'(instr_b), 32'hC0000);
        chk("b_st9_alu", 32'(alu_b), 32'h00009);
        mem_b(20'hF0000, 20'h00009, 20'h0, 4'h4);
        chk("b_ld9_valid", 32'(vo_b), 32'd1);
        chk("b_ld9_mrd", 32'(mrd_b), 32'h0BEEF);
        chk("b_ld9_addr", 32'(addr_b), 32'h4);
        chk("b_ld9_alu", 32'(alu_b), 32'h00009);
        vb = 1'b1; ib = 20'h20001; ab = 20'h00007; sb = '0; db = 4'h5;
        #1 chk("b_alu_stall", 32'(stall_b), 32'd0);
        @(posedge clk); #1;
        chk("b_alu_valid", 32'(vo_b), 32'd1);
        chk("b_alu_res", 32'(alu_b), 32'h00007);
        chk("b_alu_mrd", 32'(mrd_b), 32'h0);

        // Reset during BUSY aborts a store to idx 9
        vb = 1'b1; ib = 20'hC0000; ab = 20'h00009; sb = 20'h12121; db = 4'h0;
        #1 chk("b_abort_stall0", 32'(stall_b), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk("b_abort_stall_rst", 32'(stall_b), 32'd0);
        @(posedge clk); #1;
        chk("b_abort_instr", 32'(instr_b), 32'hC0000);
        chk("b_abort_valid", 32'(vo_b), 32'd0);
        rst = 1'b0;
        mem_b(20'hF0000, 20'h00009, 20'h0, 4'h6);
        chk("b_abort_ld_mrd", 32'(mrd_b), 32'h0BEEF);
        chk("b_abort_ld_valid", 32'(vo_b), 32'd1);

        // Out-of-range index 210 on the DEPTH=200 instance
        mem_b(20'hC0000, 20'h000D2, 20'h33333, 4'h0);
        chk("b_oor_st_valid", 32'(vo_b), 32'd1);
`ifdef MEMSTAGE_RANGE_CHECK_EN
        chk("b_oor_rerr_set", 32'(rerr_b), 32'd1);
`endif
        vb = 1'b0;
        @(posedge clk); #1;
        chk("b_oor_idle_valid", 32'(vo_b), 32'd0);
`ifdef MEMSTAGE_RANGE_CHECK_EN
        chk("b_oor_rerr_clr", 32'(rerr_b), 32'd0);
`endif
        mem_b(20'hF0000, 20'h000D2, 20'h0, 4'h8);
        chk("b_oor_ld_mrd", 32'(mrd_b), 32'h0);
        chk("b_oor_ld_valid", 32'(vo_b), 32'd1);
        chk("b_oor_ld_addr", 32'(addr_b), 32'h8);
        vb = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly upstream of the write-back stage.
- Takes the executed instruction, ALU result, store data and destination register.
- Performs data-memory loads and stores against an internal word-addressed RAM.
- Registers instruction, ALU result, memory read data and destination address into the MEM/WB boundary that write-back consumes.
- Handles multi-cycle memory latency with a stall to upstream and bubble insertion downstream.

Parameters:
- DEPTH, 256: number of 20-bit data-memory words.
- ADDR_W, 8: memory index width; DEPTH <= 2**ADDR_W.
- MEM_LATENCY, 1: cycles a load or store occupies the stage, minimum 1.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  upstream presents an instruction.
- instruction_in  input  20  executed instruction; opcode is [19:16].
- aluResult_in  input  20  ALU result; memory index is [ADDR_W-1:0].
- storeData_in  input  20  data to store.
- address_in  input  4  destination register.
- stall  output  1  combinational; upstream must hold its inputs this cycle.
- instruction  output  20  registered, to write-back.
- aluRESULTout  output  20  registered.
- memoryReadData  output  20  registered load data; 0 when not a load.
- address  output  4  registered destination register.
- valid_out  output  1  registered; 1 = real instruction in MEM/WB.

Behaviour:
- Opcode classes:
  - LOAD = 4'b1111 or 4'b1101.
  - STORE = 4'b1100.
  - Every other opcode is ALU and passes through.
- BUBBLE is instruction = 20'hC0000, with aluRESULTout, memoryReadData and address all 0, and valid_out = 0. Opcode 1100 makes write-back drop the register write.
- Reset: all outputs take BUBBLE values, state = IDLE, counter = 0, stall = 0. RAM contents are not cleared.
- State machine has two states, IDLE and BUSY, plus a counter cnt of width clog2(MEM_LATENCY)+1.
- IDLE, valid_in = 0: BUBBLE is registered next edge.
- IDLE, ALU op, or a memory op with MEM_LATENCY = 1:
  - Inputs are registered next edge; valid_out = 1.
  - LOAD: memoryReadData = RAM[idx], read before any same-edge write.
  - STORE: RAM[idx] <= storeData_in at that edge; memoryReadData = 0.
- IDLE, memory op with MEM_LATENCY > 1:
  - stall = 1 this cycle.
  - Operands are captured; go to BUSY with cnt = MEM_LATENCY-2; BUBBLE is registered.
- BUSY with cnt != 0: stall = 1, cnt decrements, BUBBLE is registered; inputs are ignored.
- BUSY with cnt == 0:
  - stall = 0; the access uses the captured operands and ignores the still-held inputs.
  - Result is registered and the state returns to IDLE.
- Memory op timing: the result appears MEM_LATENCY edges after acceptance. Upstream sees stall = 1 for exactly MEM_LATENCY-1 cycles.
- ALU-op throughput is 1 per cycle, latency 1.
- Index wraps modulo 2**ADDR_W. Accesses with index >= DEPTH read 0 and drop the write, unless MEMSTAGE_RANGE_CHECK_EN changes this.
- Reset in BUSY: the access is aborted, no store is committed, stall drops the same cycle reset is sampled, and outputs become BUBBLE.
- Back-to-back memory ops: the second one is accepted in the cycle after the first completes.

Optional Feature:
- Macro MEMSTAGE_RANGE_CHECK_EN.
- Defined:
  - Extra output port range_error (1-bit, registered, reset 0).
  - It is set for one cycle alongside valid_out when a LOAD or STORE index is >= DEPTH.
  - The store is suppressed and memoryReadData = 0.
- Undefined: no port is added; out-of-range behaviour is as above with no indication.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_LOAD = 4'b1111, OP_LOADI = 4'b1101, OP_STORE = 4'b1100;
  - BUBBLE_INSTR = 20'hC0000;
  - INSTR_W = 20, DATA_W = 20, REG_ADDR_W = 4;
  - state enum {IDLE, BUSY}.
- One sub-module, data_ram: single-port synchronous RAM, DEPTH x 20, with a write enable, read-during-write returning old data.

Test Plan:
- Reset held 2 cycles → instruction = 20'hC0000, valid_out = 0, stall = 0.
- ALU op instruction_in = 20'h3_0005, aluResult_in = 20'h0000A, address_in = 4'h7 → next cycle aluRESULTout = 20'h0000A, address = 7, valid_out = 1.
- MEM_LATENCY = 1: STORE with idx 5, data 20'hABCDE, then LOAD 20'hF_0000 with idx 5 → memoryReadData = 20'hABCDE one cycle after the load.
- MEM_LATENCY = 3: LOAD accepted → stall = 1 for 2 cycles, 2 BUBBLEs out, result on the 3rd edge, then the next ALU op is accepted.
- MEM_LATENCY = 3: STORE idx 9, reset asserted in the 2nd cycle, then LOAD idx 9 → old contents returned, store not committed.
- MEMSTAGE_RANGE_CHECK_EN with DEPTH = 200: STORE idx 210 → range_error = 1 for one cycle, and a later LOAD idx 210 returns 0.
